// File: rtl/fc_engine.sv
// rtl/fc_engine.sv - binary XNOR-popcount fully-connected stage with per-class scores and argmax
// Argmax tracking is built only when FC_ARGMAX_EN is defined; otherwise class_out is tied to 0.
module fc_engine #(
    parameter int IN_BITS = 960,
    parameter int N_OUT   = 10,
    parameter int CHUNK   = 60,
    parameter int OFF_W   = 9,
    parameter int SCORE_W = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       begin_fc,
    input  logic [IN_BITS-1:0]         fmap,
    input  logic [N_OUT*IN_BITS-1:0]   weights,
    input  logic [N_OUT*OFF_W-1:0]     offset,
    output logic                       busy,
    output logic                       done_fc,
    output logic [N_OUT*SCORE_W-1:0]   scores,
    output logic [$clog2(N_OUT)-1:0]   class_out
);

    localparam int NCHUNK = IN_BITS / CHUNK;
    localparam int K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int N_W    = $clog2(N_OUT);
    localparam int P_W    = $clog2(CHUNK + 1);

    typedef enum logic {IDLE, ACC} state_t;

    state_t                     state_q, state_d;
    logic [IN_BITS-1:0]         act_q, act_d;
    logic [K_W-1:0]             k_q, k_d;
    logic [N_W-1:0]             n_q, n_d;
    logic [SCORE_W-1:0]         acc_q, acc_d;
    logic [N_OUT*SCORE_W-1:0]   scores_q, scores_d;
    logic                       done_q, done_d;

    logic [CHUNK-1:0]           xnor_bits;
    logic [P_W-1:0]             pop;
    logic [SCORE_W-1:0]         neuron_score;
    logic                       last_chunk, last_neuron, accept;

    assign accept      = (state_q == IDLE) && begin_fc;
    assign last_chunk  = (k_q == K_W'(NCHUNK - 1));
    assign last_neuron = (n_q == N_W'(N_OUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            act_q    <= '0;
            k_q      <= '0;
            n_q      <= '0;
            acc_q    <= '0;
            scores_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            act_q    <= act_d;
            k_q      <= k_d;
            n_q      <= n_d;
            acc_q    <= acc_d;
            scores_q <= scores_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (begin_fc) state_d = ACC;
            ACC:     if (last_chunk && last_neuron) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One CHUNK-wide XNOR-popcount per cycle; the neuron score folds in the offset on its last chunk.
    always_comb begin
        xnor_bits = ~(act_q[32'(k_q) * CHUNK +: CHUNK] ^
                      weights[32'(n_q) * IN_BITS + 32'(k_q) * CHUNK +: CHUNK]);
        pop = '0;
        for (int i = 0; i < CHUNK; i++) begin
            pop = pop + P_W'(xnor_bits[i]);
        end
        neuron_score = acc_q + SCORE_W'(pop) + SCORE_W'(offset[32'(n_q) * OFF_W +: OFF_W]);
    end

    always_comb begin
        act_d    = act_q;
        k_d      = k_q;
        n_d      = n_q;
        acc_d    = acc_q;
        scores_d = scores_q;
        done_d   = 1'b0;
        if (accept) begin
            act_d = fmap;
            k_d   = '0;
            n_d   = '0;
            acc_d = '0;
        end else if (state_q == ACC) begin
            if (!last_chunk) begin
                acc_d = acc_q + SCORE_W'(pop);
                k_d   = k_q + 1'b1;
            end else begin
                scores_d[32'(n_q) * SCORE_W +: SCORE_W] = neuron_score;
                acc_d  = '0;
                k_d    = '0;
                n_d    = n_q + 1'b1;
                done_d = last_neuron;
            end
        end
    end

    always_comb begin
        busy    = (state_q == ACC);
        done_fc = done_q;
        scores  = scores_q;
    end

`ifdef FC_ARGMAX_EN
    logic [N_W-1:0]     best_q, best_d;
    logic [SCORE_W-1:0] max_q, max_d;
    logic [N_W-1:0]     class_q, class_d;
    logic               beats_max;

    // Strict comparison keeps the lower index on ties.
    assign beats_max = (neuron_score > max_q);

    always_comb begin
        best_d  = best_q;
        max_d   = max_q;
        class_d = class_q;
        if (accept) begin
            best_d = '0;
            max_d  = '0;
        end else if (state_q == ACC && last_chunk) begin
            if (beats_max) begin
                best_d = n_q;
                max_d  = neuron_score;
            end
            if (last_neuron) class_d = beats_max ? n_q : best_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_q  <= '0;
            max_q   <= '0;
            class_q <= '0;
        end else begin
            best_q  <= best_d;
            max_q   <= max_d;
            class_q <= class_d;
        end
    end

    assign class_out = class_q;
`else
    assign class_out = '0;
`endif

endmodule
